instruction_fetch: RTL and testbench

//  Instruction-fetch stage directly upstream of the decode stage. Holds the PC, reads instruction memory

---
 rtl/instruction_fetch.sv | 182 ++++++++++++++++++
 tb/tb_instruction_fetch.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage feeding decode.
// Holds the PC, issues one imem read at a time over a req/rvalid handshake of variable latency
// and presents the returned instruction with its PC under a valid/ready handshake to decode.
// Later stages may redirect the PC; halt stops new requests without cancelling one in flight.
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   imem_req, imem_addr           one-cycle read request and its word address (= pc)
//   imem_rdata, imem_rvalid       read response, exactly one per request
//   if_valid, if_instr, if_pc     instruction and its PC offered to decode
//   if_pred_jump                  fetch already followed the jump in if_instr
//   id_ready                      decode accepts this cycle
//   redirect, redirect_pc         load a new PC and squash wrong-path work
//   halt                          level: no new requests while high
//
// Build option: define JUMP_PREDECODE_EN to follow J/JAL targets at capture time.
// Without it the PC always steps by one and if_pred_jump is tied low.

module instruction_fetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_rvalid,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              if_pred_jump,
  input  logic              id_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt
);

  typedef enum logic [1:0] {StFetch, StWait, StHold} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              discard_q, discard_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] ifpc_q, ifpc_d;
  logic [ADDR_W-1:0] next_pc;
  logic              is_jump;

`ifdef JUMP_PREDECODE_EN
  logic pj_q, pj_d;

  // J (0x02) and JAL (0x03) carry a 26-bit word target within the current region.
  always_comb begin
    is_jump = (imem_rdata[31:26] == 6'h2) || (imem_rdata[31:26] == 6'h3);
    next_pc = is_jump ? {pc_q[ADDR_W-1:26], imem_rdata[25:0]} : pc_q + ADDR_W'(1);
  end
`else
  always_comb begin
    is_jump = 1'b0;
    next_pc = pc_q + ADDR_W'(1);
  end
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    req_d     = 1'b0;
    valid_d   = valid_q;
    instr_d   = instr_q;
    ifpc_d    = ifpc_q;
`ifdef JUMP_PREDECODE_EN
    pj_d      = pj_q;
`endif

    // req_q marks the cycle a request is actually on the bus; it is decided one edge ahead
    // from the halt level so the output stays registered.
    case (state_q)
      StFetch: begin
        if (req_q) state_d = StWait;
        else       req_d   = !halt;
      end
      StWait: begin
        if (imem_rvalid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = StFetch;
            req_d     = !halt;
          end else begin
            instr_d = imem_rdata;
            ifpc_d  = pc_q;
            valid_d = 1'b1;
            pc_d    = next_pc;
            state_d = StHold;
`ifdef JUMP_PREDECODE_EN
            pj_d    = is_jump;
`endif
          end
        end
      end
      StHold: begin
        if (id_ready) begin
          valid_d = 1'b0;
          state_d = StFetch;
          req_d   = !halt;
        end
      end
      default: state_d = StFetch;
    endcase

    // Redirect overrides the normal flow; an outstanding request must still drain its response.
    if (redirect) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      case (state_q)
        StFetch: begin
          if (req_q) begin
            state_d   = StWait;
            discard_d = 1'b1;
          end else begin
            state_d = StFetch;
            req_d   = !halt;
          end
        end
        StWait: begin
          if (imem_rvalid) begin
            state_d   = StFetch;
            discard_d = 1'b0;
            req_d     = !halt;
          end else begin
            state_d   = StWait;
            discard_d = 1'b1;
          end
        end
        default: begin
          state_d   = StFetch;
          discard_d = 1'b0;
          req_d     = !halt;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      instr_q   <= '0;
      ifpc_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      ifpc_q    <= ifpc_d;
    end
  end

`ifdef JUMP_PREDECODE_EN
  always_ff @(posedge clk) begin
    if (rst) pj_q <= 1'b0;
    else     pj_q <= pj_d;
  end
  assign if_pred_jump = pj_q;
`else
  assign if_pred_jump = 1'b0;
`endif

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign if_valid  = valid_q;
  assign if_instr  = instr_q;
  assign if_pc     = ifpc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a small memory model with programmable latency answers
// each request; a monitor logs every decode transfer. Inputs change 1ns after the rising edge,
// outputs are checked on the falling edge.

module tb_instruction_fetch;

  localparam int unsigned ADDR_W = 32;

  logic              clk;
  logic              rst;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              imem_rvalid;
  logic              if_valid;
  logic [31:0]       if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic              if_pred_jump;
  logic              id_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;

  int total = 0;
  int bad   = 0;

  instruction_fetch #(.ADDR_W(ADDR_W), .RESET_PC('0)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_rvalid  (imem_rvalid),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .if_pred_jump (if_pred_jump),
    .id_ready     (id_ready),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .halt         (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: request seen in cycle c answers in cycle c+mem_lat.
  int          mem_lat  = 3;
  int          mem_cnt  = 0;
  logic [31:0] mem_pa   = '0;
  logic [31:0] jmp_addr = 32'h0000_7777;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == jmp_addr) return 32'h0800_0010;
    return 32'hA0 + a;
  endfunction

  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (rst) begin
      mem_cnt = 0;
    end else begin
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(mem_pa);
        end
      end
      if (imem_req) begin
        mem_cnt = mem_lat;
        mem_pa  = imem_addr;
      end
    end
  end

  // Transfer log.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          cyc;
  } del_t;
  del_t dq[$];
  int   cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst && if_valid && id_ready && !redirect)
      dq.push_back('{pc: if_pc, instr: if_instr, cyc: cyc});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic h);
    rst = 1'b1; halt = h; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    dq.delete();
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req) begin ok = 1'b1; break; end
    end
    if (!ok) begin total++; bad++; $display("FAIL wait_req: got timeout want imem_req"); end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin total++; bad++; $display("FAIL wait_valid: got timeout want if_valid"); end
  endtask

  task automatic test_reset();
    rst = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    mem_lat = 3;
    tick();
    tick();
    @(negedge clk);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", if_valid); end
    total++; if (if_instr !== 32'h0) begin bad++; $display("FAIL rst_instr: got %h want 0", if_instr); end
    total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h want 0", if_pc); end
    total++;
    if (if_pred_jump !== 1'b0) begin bad++; $display("FAIL rst_pj: got %b want 0", if_pred_jump); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      begin bad++; $display("FAIL first_req: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_stream();
    bit ok;
    do_reset(1'b0);
    mem_lat = 3;
    id_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dq.size() >= 3) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL stream_count: got %0d want 3", dq.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (dq[i].pc !== 32'(i) || dq[i].instr !== 32'hA0 + 32'(i)) begin
          bad++;
          $display("FAIL stream_%0d: got pc=%h instr=%h want %h/%h", i, dq[i].pc, dq[i].instr,
                   i, 32'hA0 + 32'(i));
        end
      end
      // 1 request cycle + 3 latency + 1 valid cycle per instruction.
      for (int i = 1; i < 3; i++) begin
        total++;
        if (dq[i].cyc - dq[i-1].cyc != 5) begin
          bad++;
          $display("FAIL stream_gap_%0d: got %0d want 5", i, dq[i].cyc - dq[i-1].cyc);
        end
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    do_reset(1'b0);
    mem_lat = 3;
    wait_valid(ok);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'hA0 || imem_req !== 1'b0) begin
        bad++;
        $display("FAIL stall_%0d: got v=%b pc=%h instr=%h req=%b want 1/0/a0/0", i, if_valid,
                 if_pc, if_instr, imem_req);
      end
    end
    tick();
    id_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h1)
      begin bad++; $display("FAIL stall_release: got req=%b addr=%h want 1/1", imem_req, imem_addr); end
    total++;
    if (dq.size() != 1) begin bad++; $display("FAIL stall_xfers: got %0d want 1", dq.size()); end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    do_reset(1'b0);
    mem_lat = 3;
    id_ready = 1'b1;
    wait_req(ok);
    total++;
    if (imem_addr !== 32'h0) begin bad++; $display("FAIL rdw_first: got %h want 0", imem_addr); end
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    wait_req(ok);
    total++;
    if (imem_addr !== 32'h40) begin bad++; $display("FAIL rdw_addr: got %h want 40", imem_addr); end
    total++;
    if (dq.size() != 0) begin bad++; $display("FAIL rdw_dropped: got %0d xfers want 0", dq.size()); end
    wait_valid(ok);
    total++;
    if (if_pc !== 32'h40 || if_instr !== 32'hE0)
      begin bad++; $display("FAIL rdw_data: got pc=%h instr=%h want 40/e0", if_pc, if_instr); end
  endtask

  task automatic test_redirect_hold();
    bit ok;
    do_reset(1'b0);
    mem_lat = 1;
    wait_valid(ok);
    tick();
    id_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h20;
    tick();
    redirect = 1'b0;
    @(negedge clk);
    total++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h20) begin
      bad++;
      $display("FAIL rdh_state: got v=%b req=%b addr=%h want 0/1/20", if_valid, imem_req, imem_addr);
    end
    total++;
    if (dq.size() != 0) begin bad++; $display("FAIL rdh_squash: got %0d xfers want 0", dq.size()); end
  endtask

  task automatic test_halt();
    bit ok;
    do_reset(1'b1);
    mem_lat = 2;
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (imem_req !== 1'b0) begin bad++; $display("FAIL halt_%0d: got req=%b want 0", i, imem_req); end
    end
    tick();
    halt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      begin bad++; $display("FAIL halt_release: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    // PC wrap from all-ones.
    do_reset(1'b1);
    id_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = '1;
    tick();
    redirect = 1'b0;
    halt = 1'b0;
    wait_req(ok);
    total++;
    if (imem_addr !== 32'hFFFF_FFFF)
      begin bad++; $display("FAIL wrap_req: got %h want ffffffff", imem_addr); end
    wait_valid(ok);
    total++;
    if (if_pc !== 32'hFFFF_FFFF || if_instr !== 32'h9F)
      begin bad++; $display("FAIL wrap_data: got pc=%h instr=%h want ffffffff/9f", if_pc, if_instr); end
    wait_req(ok);
    total++;
    if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_next: got %h want 0", imem_addr); end
  endtask

  task automatic test_predecode();
    bit          ok;
    logic [31:0] exp_next;
    logic        exp_pj;
`ifdef JUMP_PREDECODE_EN
    exp_next = 32'h10;
    exp_pj   = 1'b1;
`else
    exp_next = 32'h6;
    exp_pj   = 1'b0;
`endif
    do_reset(1'b1);
    mem_lat = 2;
    jmp_addr = 32'h5;
    id_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h5;
    tick();
    redirect = 1'b0;
    halt = 1'b0;
    wait_req(ok);
    total++;
    if (imem_addr !== 32'h5) begin bad++; $display("FAIL pd_req: got %h want 5", imem_addr); end
    wait_valid(ok);
    total++;
    if (if_pc !== 32'h5 || if_instr !== 32'h0800_0010 || if_pred_jump !== exp_pj) begin
      bad++;
      $display("FAIL pd_data: got pc=%h instr=%h pj=%b want 5/08000010/%b", if_pc, if_instr,
               if_pred_jump, exp_pj);
    end
    tick();
    id_ready = 1'b1;
    wait_req(ok);
    total++;
    if (imem_addr !== exp_next)
      begin bad++; $display("FAIL pd_next: got %h want %h", imem_addr, exp_next); end
  endtask

  initial begin
    rst = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    imem_rdata = '0; imem_rvalid = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_halt();
    test_predecode();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t want completion", $time);
    $fatal(1, "timeout");
  end

endmodule
